boid_frame_reader: RTL and testbench

//  Read side of the boid display memory. Scans the 640x480 frame in raster order and

---
 rtl/boid_frame_reader_if.sv | 35 +++
 rtl/boid_frame_reader.sv | 128 ++++++++++++
 tb/tb_boid_frame_reader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/boid_frame_reader_if.sv
// Display-side bus of the boid frame reader: the 1-bit display RAM read port plus the VGA outputs.
interface boid_frame_reader_if #(
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0] boid_read_address;
    logic                  boid_read_data;
    logic                  hSync;
    logic                  vSync;
    logic [3:0]            VGA_R;
    logic [3:0]            VGA_G;
    logic [3:0]            VGA_B;
    logic                  screenEnd_out;

    modport master (
        output boid_read_address,
        input  boid_read_data,
        output hSync,
        output vSync,
        output VGA_R,
        output VGA_G,
        output VGA_B,
        output screenEnd_out
    );

    modport slave (
        input  boid_read_address,
        output boid_read_data,
        input  hSync,
        input  vSync,
        input  VGA_R,
        input  VGA_G,
        input  VGA_B,
        input  screenEnd_out
    );
endinterface

// File: rtl/boid_frame_reader.sv
// Raster scan of the boid display memory: generates VGA timing at half the system clock,
// reads one bit per pixel and overlays the scary boid as a red square.
module boid_frame_reader #(
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33,
    parameter int         ADDR_WIDTH = 19,
    parameter int         SCARY_HALF = 2,
    parameter logic [11:0] BG_COLOUR = 12'h002
) (
    input  logic                       clock,
    input  logic                       resetn,
    boid_frame_reader_if.master        bus,
    input  logic [9:0]                 scary_boid_x,
    input  logic [8:0]                 scary_boid_y
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [31:0] LINE_WORDS = 32'(H_ACTIVE);
    localparam logic signed [10:0] HALF = 11'(SCARY_HALF);

    logic                  phase_q, phase_d;
    logic [9:0]            h_q, h_d;
    logic [9:0]            v_q, v_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [11:0]           rgb_q, rgb_d;
    logic                  screen_end_q, screen_end_d;

    logic                  pix_en;
    logic                  cur_active;
    logic                  scary_hit;
    logic signed [10:0]    dx;
    logic signed [10:0]    dy;

    assign pix_en = phase_q;

    // The address is formed from the next counter position so that the RAM bit for a
    // pixel arrives just in time for the output stage while the counters still hold it.
    always_comb begin
        phase_d      = ~phase_q;
        h_d          = h_q;
        v_d          = v_q;
        addr_d       = addr_q;
        screen_end_d = 1'b0;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            if ((h_d < H_ACT) && (v_d < V_ACT)) begin
                addr_d = ADDR_WIDTH'({22'd0, v_d} * LINE_WORDS + {22'd0, h_d});
            end else begin
                addr_d = '0;
            end
            screen_end_d = (h_d == 10'd0) && (v_d == V_ACT);
        end
    end

    always_comb begin
        cur_active = (h_q < H_ACT) && (v_q < V_ACT);
        dx         = $signed({1'b0, h_q}) - $signed({1'b0, scary_boid_x});
        dy         = $signed({1'b0, v_q}) - $signed({2'b00, scary_boid_y});
        scary_hit  = (dx >= -HALF) && (dx <= HALF) && (dy >= -HALF) && (dy <= HALF);
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        rgb_d      = rgb_q;
        if (pix_en) begin
            hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
            vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
            if (!cur_active) begin
                rgb_d = 12'h000;
            end else if (scary_hit) begin
                rgb_d = 12'hF00;
            end else if (bus.boid_read_data) begin
                rgb_d = 12'hFFF;
            end else begin
                rgb_d = BG_COLOUR;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase_q      <= 1'b0;
            h_q          <= 10'd0;
            v_q          <= 10'd0;
            addr_q       <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= 12'h000;
            screen_end_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            h_q          <= h_d;
            v_q          <= v_d;
            addr_q       <= addr_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            screen_end_q <= screen_end_d;
        end
    end

    assign bus.boid_read_address = addr_q;
    assign bus.hSync             = hsync_q;
    assign bus.vSync             = vsync_q;
    assign bus.VGA_R             = rgb_q[11:8];
    assign bus.VGA_G             = rgb_q[7:4];
    assign bus.VGA_B             = rgb_q[3:0];
    assign bus.screenEnd_out     = screen_end_q;

endmodule

// File: tb/tb_boid_frame_reader.sv
// Bench for boid_frame_reader: a shrunken-geometry instance run over whole frames and a
// full-size instance over its first lines, both compared every clock against a pixel-index model.
module tb_boid_frame_reader;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
    } geom_t;

    localparam geom_t SMALL = '{ha: 16, hfp: 2, hs: 4, hbp: 2, va: 12, vfp: 2, vs: 1, vbp: 2};
    localparam geom_t LARGE = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33};

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] scary_x;
    logic [8:0] scary_y;

    always #5 clock = ~clock;

    boid_frame_reader_if #(.ADDR_WIDTH(8))  small_if ();
    boid_frame_reader_if #(.ADDR_WIDTH(19)) large_if ();

    boid_frame_reader #(
        .H_ACTIVE(SMALL.ha), .H_FP(SMALL.hfp), .H_SYNC(SMALL.hs), .H_BP(SMALL.hbp),
        .V_ACTIVE(SMALL.va), .V_FP(SMALL.vfp), .V_SYNC(SMALL.vs), .V_BP(SMALL.vbp),
        .ADDR_WIDTH(8)
    ) dut_small (
        .clock(clock),
        .resetn(resetn),
        .bus(small_if),
        .scary_boid_x(scary_x),
        .scary_boid_y(scary_y)
    );

    boid_frame_reader dut_large (
        .clock(clock),
        .resetn(resetn),
        .bus(large_if),
        .scary_boid_x(scary_x),
        .scary_boid_y(scary_y)
    );

    // Display RAM with one clock of read latency; the full-size instance sees an empty memory.
    logic small_mem [0:255];
    always @(posedge clock) small_if.boid_read_data <= small_mem[small_if.boid_read_address];
    assign large_if.boid_read_data = 1'b0;

    int          k;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_addr_s, exp_addr_l;
    logic [13:0] exp_out_s, exp_out_l;
    logic        exp_se_s, exp_se_l;

    function automatic int line_len(geom_t g);
        return g.ha + g.hfp + g.hs + g.hbp;
    endfunction

    function automatic int frame_len(geom_t g);
        return line_len(g) * (g.va + g.vfp + g.vs + g.vbp);
    endfunction

    function automatic int pix_addr(geom_t g, int p);
        int q = p % frame_len(g);
        int h = q % line_len(g);
        int v = q / line_len(g);
        return ((h < g.ha) && (v < g.va)) ? h + v * g.ha : 0;
    endfunction

    function automatic logic [13:0] pix_out(geom_t g, int p, int sx, int sy, logic ram_bit);
        int q = p % frame_len(g);
        int h = q % line_len(g);
        int v = q / line_len(g);
        logic hs = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hs));
        logic vs = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vs));
        logic [11:0] rgb;
        if (!((h < g.ha) && (v < g.va)))                             rgb = 12'h000;
        else if ((h - sx >= -2) && (h - sx <= 2) && (v - sy >= -2) && (v - sy <= 2)) rgb = 12'hF00;
        else if (ram_bit)                                            rgb = 12'hFFF;
        else                                                         rgb = 12'h002;
        return {hs, vs, rgb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, k);
    endtask

    task automatic compare_all();
        check("small_addr", 32'(small_if.boid_read_address), exp_addr_s);
        check("small_sync_rgb", 32'({small_if.hSync, small_if.vSync, small_if.VGA_R,
                                     small_if.VGA_G, small_if.VGA_B}), 32'(exp_out_s));
        check("small_screen_end", 32'(small_if.screenEnd_out), 32'(exp_se_s));
        check("large_addr", 32'(large_if.boid_read_address), exp_addr_l);
        check("large_sync_rgb", 32'({large_if.hSync, large_if.vSync, large_if.VGA_R,
                                     large_if.VGA_G, large_if.VGA_B}), 32'(exp_out_l));
        check("large_screen_end", 32'(large_if.screenEnd_out), 32'(exp_se_l));
    endtask

    task automatic set_reset_expect();
        exp_addr_s = 0;
        exp_addr_l = 0;
        exp_out_s  = {2'b11, 12'h000};
        exp_out_l  = {2'b11, 12'h000};
        exp_se_s   = 1'b0;
        exp_se_l   = 1'b0;
    endtask

    // Edge k after reset release: pixel index m = k/2 is loaded on even edges, and the
    // outputs then show pixel m-1 using the scary position present at that edge.
    task automatic check_output();
        if (k % 2 == 0) begin
            int m = k / 2;
            int p = m - 1;
            exp_out_s  = pix_out(SMALL, p, int'(scary_x), int'(scary_y), small_mem[pix_addr(SMALL, p)]);
            exp_out_l  = pix_out(LARGE, p, int'(scary_x), int'(scary_y), 1'b0);
            exp_addr_s = 32'(pix_addr(SMALL, m));
            exp_addr_l = 32'(pix_addr(LARGE, m));
            exp_se_s   = (m % frame_len(SMALL)) == SMALL.va * line_len(SMALL);
            exp_se_l   = (m % frame_len(LARGE)) == LARGE.va * line_len(LARGE);
        end else begin
            exp_se_s = 1'b0;
            exp_se_l = 1'b0;
        end
        compare_all();
    endtask

    task automatic apply_stimulus();
        if ($urandom_range(0, 4) != 0) begin
            scary_x = 10'($urandom_range(0, 25));
            scary_y = 9'($urandom_range(0, 18));
        end else begin
            scary_x = 10'($urandom_range(0, 1023));
            scary_y = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic run_clocks(input int n, input bit rand_scary);
        repeat (n) begin
            @(posedge clock);
            k++;
            #1;
            check_output();
            if (rand_scary && ($urandom_range(0, 7) == 0)) apply_stimulus();
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) small_mem[i] = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        resetn  = 1'b0;
        scary_x = 10'd4;
        scary_y = 9'd4;
        k       = 0;
        fill_mem();
        small_mem[4 + 4 * SMALL.ha] = 1'b1;
        set_reset_expect();
        repeat (2) @(negedge clock);
        compare_all();
        resetn = 1'b1;

        $display("[TB] scary boid at (4,4) over a set memory bit");
        run_clocks(2 * frame_len(SMALL), 1'b0);

        $display("[TB] scary boid at the (0,0) corner");
        scary_x = 10'd0;
        scary_y = 9'd0;
        run_clocks(2 * frame_len(SMALL), 1'b0);

        $display("[TB] scary boid moving randomly");
        run_clocks(2 * frame_len(SMALL), 1'b1);
        run_clocks(2 * (3 * line_len(SMALL) + 5), 1'b1);

        $display("[TB] asynchronous reset mid-line");
        #2 resetn = 1'b0;
        #1 set_reset_expect();
        compare_all();
        fill_mem();
        @(posedge clock);
        #1 compare_all();
        @(negedge clock);
        resetn = 1'b1;
        k = 0;
        run_clocks(600, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
